wb_commit_stage: RTL and testbench

- Final pipeline stage. Consumes the MEM/WB register outputs (wb_*) and commits architectural state.
- Selects the register-file write data and drives the GPR write port.
- Holds the architectural HI/LO registers.
- Pushes retired GPR writes into a small trace FIFO that feeds the debug-trace interface. When that FIFO cannot accept a write, the block back-pressures the pipeline.

---
 rtl/wb_commit_stage_pkg.sv | 24 ++
 rtl/wb_trace_fifo.sv | 63 ++++++
 rtl/wb_commit_stage.sv | 116 +++++++++++
 tb/tb_wb_commit_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_stage_pkg.sv
// Shared definitions for the write-back / commit stage and its trace FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_commit_stage_pkg;

  // wb_rhilo encodings for MFHI / MFLO
  localparam logic [1:0] RHILO_HI = 2'b10;
  localparam logic [1:0] RHILO_LO = 2'b01;

  // wb_whilo bit positions
  localparam int WHILO_HI_BIT = 1;
  localparam int WHILO_LO_BIT = 0;

  // Default trace FIFO depth (power of two, >= 2)
  localparam int TRACE_DEPTH_DEF = 4;

  // One retired GPR write as seen by the debug-trace consumer (69 bits)
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Circular-buffer FIFO holding retired GPR writes for the debug-trace port.
// Latency: 1 cycle push-to-head (no fall-through); head is a direct read of the rd_ptr slot.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; caller stalls.
// Ports: clk, reset (async, active-high); push/din write side; pop/dout read side;
//        count (0..DEPTH), full, empty status.
module wb_trace_fifo
  import wb_commit_stage_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH_DEF,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  trace_entry_t     din,
  input  logic             pop,
  output trace_entry_t     dout,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  trace_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is intentionally not reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/wb_commit_stage.sv
// Final pipeline stage: selects GPR write data, commits GPR/HI/LO, pushes retired GPR writes to a trace FIFO.
// Latency: GPR write port combinational; HI/LO update at the clock edge; trace entry visible 1 cycle after push.
// Backpressure: wb_stall holds MEM/WB and upstream when a trace push meets a full FIFO with no pop this cycle.
// Ports: clk, reset (async, active-high); wb_* retiring instruction; rf_* GPR write port;
//        hi_q/lo_q architectural HI/LO; wb_stall; trace_valid/trace_ready + debug_wb_* trace head.
// Optional: define WB_RETIRE_CNT_EN to add retire_cnt, a wrapping count of non-bubble retirements.
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter int TRACE_DEPTH = TRACE_DEPTH_DEF,
  parameter int PTR_W       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_res,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  input  logic [31:0] wb_rdata,
  input  logic        wb_load,
  input  logic        wb_al,
  input  logic        wb_regwen,
  input  logic [5:0]  wb_wreg,
  input  logic [1:0]  wb_rhilo,
  input  logic [1:0]  wb_whilo,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic        wb_stall,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  logic [31:0]    wdata;
  logic           push_req;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [PTR_W:0] fifo_count;
  trace_entry_t   push_entry;
  trace_entry_t   head_entry;

  // Write-data select; MFHI/MFLO read the pre-edge HI/LO.
  always_comb begin
    wdata = wb_res;
    if (wb_load)                  wdata = wb_rdata;
    else if (wb_al)               wdata = wb_pc + 32'd8;
    else if (wb_rhilo == RHILO_HI) wdata = hi_q;
    else if (wb_rhilo == RHILO_LO) wdata = lo_q;
  end

  // r0 writes reach the register file (which drops them) but never the trace.
  assign push_req = wb_regwen & ~wb_wreg[5] & (wb_wreg[4:0] != 5'd0);
  assign pop      = trace_ready & ~fifo_empty;
  assign wb_stall = push_req & fifo_full & ~pop;
  assign push     = push_req & ~wb_stall;

  assign rf_wen   = wb_regwen & ~wb_wreg[5] & ~wb_stall;
  assign rf_waddr = wb_wreg[4:0];
  assign rf_wdata = wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!wb_stall) begin
      if (wb_whilo[WHILO_HI_BIT]) hi_q <= wb_hi;
      if (wb_whilo[WHILO_LO_BIT]) lo_q <= wb_lo;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if (!wb_stall && (wb_regwen || (|wb_whilo))) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

  assign push_entry = '{pc: wb_pc, wnum: wb_wreg[4:0], wdata: wdata};

  wb_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .PTR_W (PTR_W)
  ) u_trace_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign trace_valid       = (fifo_count != '0);
  assign debug_wb_rf_wen   = {4{trace_valid}};
  assign debug_wb_pc       = head_entry.pc;
  assign debug_wb_rf_wnum  = head_entry.wnum;
  assign debug_wb_rf_wdata = head_entry.wdata;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: directed literal checks plus randomized traffic against a queue-based model.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// Build with WB_RETIRE_CNT_EN defined to also check retire_cnt.
module tb_wb_commit_stage;
  import wb_commit_stage_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_pc, wb_res, wb_hi, wb_lo, wb_rdata;
  logic        wb_load, wb_al, wb_regwen;
  logic [5:0]  wb_wreg;
  logic [1:0]  wb_rhilo, wb_whilo;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, hi_q, lo_q;
  logic        wb_stall, trace_valid, trace_ready;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  wb_commit_stage #(.TRACE_DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .wb_pc(wb_pc), .wb_res(wb_res), .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_rdata(wb_rdata),
    .wb_load(wb_load), .wb_al(wb_al), .wb_regwen(wb_regwen), .wb_wreg(wb_wreg),
    .wb_rhilo(wb_rhilo), .wb_whilo(wb_whilo),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_q(hi_q), .lo_q(lo_q), .wb_stall(wb_stall),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  trace_entry_t mq[$];
  logic [31:0]  mhi, mlo, mcnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, check outputs against the model, then advance the model
  // to the state the coming rising edge must produce.
  initial begin : compare
    logic        m_full, m_pop, m_preq, m_stall, m_wen;
    logic [31:0] m_wd;
    mhi = 0; mlo = 0; mcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mq.delete();
        mhi = 0; mlo = 0; mcnt = 0;
        chk("rst_trace_valid", 32'(trace_valid), 32'd0);
        chk("rst_dbg_wen", 32'(debug_wb_rf_wen), 32'd0);
        chk("rst_stall", 32'(wb_stall), 32'd0);
        chk("rst_hi", hi_q, 32'd0);
        chk("rst_lo", lo_q, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("rst_retire_cnt", retire_cnt, 32'd0);
`endif
      end else begin
        if (wb_load)               m_wd = wb_rdata;
        else if (wb_al)            m_wd = wb_pc + 32'd8;
        else if (wb_rhilo == 2'b10) m_wd = mhi;
        else if (wb_rhilo == 2'b01) m_wd = mlo;
        else                       m_wd = wb_res;
        m_full  = (mq.size() == DEPTH);
        m_pop   = (mq.size() != 0) && trace_ready;
        m_preq  = wb_regwen && !wb_wreg[5] && (wb_wreg[4:0] != 5'd0);
        m_stall = m_preq && m_full && !m_pop;
        m_wen   = wb_regwen && !wb_wreg[5] && !m_stall;

        chk("stall", 32'(wb_stall), 32'(m_stall));
        chk("rf_wen", 32'(rf_wen), 32'(m_wen));
        chk("rf_waddr", 32'(rf_waddr), 32'(wb_wreg[4:0]));
        chk("rf_wdata", rf_wdata, m_wd);
        chk("hi_q", hi_q, mhi);
        chk("lo_q", lo_q, mlo);
        chk("trace_valid", 32'(trace_valid), 32'(mq.size() != 0));
        chk("dbg_wen", 32'(debug_wb_rf_wen), (mq.size() != 0) ? 32'hf : 32'h0);
        if (mq.size() != 0) begin
          chk("dbg_pc", debug_wb_pc, mq[0].pc);
          chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(mq[0].wnum));
          chk("dbg_wdata", debug_wb_rf_wdata, mq[0].wdata);
        end
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, mcnt);
`endif
        if (m_pop) void'(mq.pop_front());
        if (!m_stall) begin
          if (m_preq) mq.push_back('{pc: wb_pc, wnum: wb_wreg[4:0], wdata: m_wd});
          if (wb_whilo[1]) mhi = wb_hi;
          if (wb_whilo[0]) mlo = wb_lo;
          if (wb_regwen || (wb_whilo != 2'b00)) mcnt = mcnt + 32'd1;
        end
      end
    end
  end

  task automatic bubble();
    wb_pc = 32'h0; wb_res = 32'h0; wb_hi = 32'h0; wb_lo = 32'h0; wb_rdata = 32'h0;
    wb_load = 1'b0; wb_al = 1'b0; wb_regwen = 1'b0; wb_wreg = 6'd0;
    wb_rhilo = 2'b00; wb_whilo = 2'b00;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  initial begin : stim
    reset = 1'b1; trace_ready = 1'b0; bubble();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    smp();
    chk("lit_reset_valid", 32'(trace_valid), 32'd0);
    chk("lit_reset_dbgwen", 32'(debug_wb_rf_wen), 32'd0);
    chk("lit_reset_stall", 32'(wb_stall), 32'd0);
    chk("lit_reset_hi", hi_q, 32'd0);

    // First GPR write and its trace entry one cycle later
    nxt(); bubble(); wb_regwen = 1'b1; wb_wreg = 6'd3; wb_res = 32'h1234;
    smp();
    chk("lit_w3_wen", 32'(rf_wen), 32'd1);
    chk("lit_w3_addr", 32'(rf_waddr), 32'd3);
    chk("lit_w3_data", rf_wdata, 32'h1234);
    nxt(); bubble();
    smp();
    chk("lit_w3_tvalid", 32'(trace_valid), 32'd1);
    chk("lit_w3_wnum", 32'(debug_wb_rf_wnum), 32'd3);
    chk("lit_w3_dbgwen", 32'(debug_wb_rf_wen), 32'hf);

    // Link writes pc+8, including wrap
    nxt(); trace_ready = 1'b1; wb_al = 1'b1; wb_regwen = 1'b1; wb_wreg = 6'd31; wb_pc = 32'hbfc00100;
    smp();
    chk("lit_link", rf_wdata, 32'hbfc00108);
    nxt(); wb_pc = 32'hfffffffc;
    smp();
    chk("lit_link_wrap", rf_wdata, 32'h4);

    // HI/LO write then MFHI; same-cycle MFHI sees old HI
    nxt(); bubble(); wb_whilo = 2'b11; wb_hi = 32'haa; wb_lo = 32'hbb;
    nxt(); bubble(); wb_regwen = 1'b1; wb_wreg = 6'd5; wb_rhilo = 2'b10;
    smp();
    chk("lit_mfhi", rf_wdata, 32'haa);
    nxt(); bubble(); wb_regwen = 1'b1; wb_wreg = 6'd6; wb_rhilo = 2'b10; wb_whilo = 2'b10; wb_hi = 32'hcc;
    smp();
    chk("lit_mfhi_old", rf_wdata, 32'haa);
    nxt(); bubble();
    smp();
    chk("lit_hi_new", hi_q, 32'hcc);
    chk("lit_lo_kept", lo_q, 32'hbb);

    // Fill the FIFO, then stall on the fifth write
    repeat (6) nxt();
    smp();
    chk("lit_drained", 32'(trace_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      nxt(); bubble(); trace_ready = 1'b0; wb_regwen = 1'b1; wb_wreg = 6'(7 + i); wb_res = 32'(i);
    end
    nxt(); bubble(); wb_regwen = 1'b1; wb_wreg = 6'd11; wb_whilo = 2'b11; wb_hi = 32'hdd; wb_lo = 32'hee;
    smp();
    chk("lit_full_stall", 32'(wb_stall), 32'd1);
    chk("lit_full_nowen", 32'(rf_wen), 32'd0);
    chk("lit_full_head", 32'(debug_wb_rf_wnum), 32'd7);
    nxt();
    smp();
    chk("lit_stall_hi_kept", hi_q, 32'hcc);
    nxt(); trace_ready = 1'b1;
    smp();
    chk("lit_pop_unstall", 32'(wb_stall), 32'd0);
    chk("lit_pop_wen", 32'(rf_wen), 32'd1);
    nxt(); bubble(); trace_ready = 1'b0;
    smp();
    chk("lit_hi_after", hi_q, 32'hdd);
    chk("lit_lo_after", lo_q, 32'hee);
    chk("lit_head_next", 32'(debug_wb_rf_wnum), 32'd8);
    nxt(); wb_regwen = 1'b1; wb_wreg = 6'd12;
    smp();
    chk("lit_still_full", 32'(wb_stall), 32'd1);

    // r0 and non-GPR destinations
    nxt(); bubble(); trace_ready = 1'b1;
    repeat (6) nxt();
    smp();
    chk("lit_drained2", 32'(trace_valid), 32'd0);
    nxt(); wb_regwen = 1'b1; wb_wreg = 6'd0;
    smp();
    chk("lit_r0_wen", 32'(rf_wen), 32'd1);
    nxt(); wb_wreg = 6'h21;
    smp();
    chk("lit_r0_nopush", 32'(trace_valid), 32'd0);
    chk("lit_nongpr_wen", 32'(rf_wen), 32'd0);
    nxt(); bubble();
    smp();
    chk("lit_nongpr_nopush", 32'(trace_valid), 32'd0);

    // Asynchronous reset with three buffered entries
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt(); bubble(); wb_regwen = 1'b1; wb_wreg = 6'(13 + i);
    end
    nxt(); bubble();
    smp();
    chk("lit_pre_rst_valid", 32'(trace_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("lit_arst_valid", 32'(trace_valid), 32'd0);
    chk("lit_arst_hi", hi_q, 32'd0);
    chk("lit_arst_lo", lo_q, 32'd0);
    smp();
    nxt(); reset = 1'b0; trace_ready = 1'b1;
`ifdef WB_RETIRE_CNT_EN
    chk("lit_cnt_zero", retire_cnt, 32'd0);
`endif
    wb_regwen = 1'b1; wb_wreg = 6'd1;
    nxt(); wb_wreg = 6'd2;
    nxt(); bubble(); wb_whilo = 2'b01; wb_lo = 32'h77;
    nxt(); bubble();
    smp();
    chk("lit_lo_77", lo_q, 32'h77);
`ifdef WB_RETIRE_CNT_EN
    chk("lit_cnt_three", retire_cnt, 32'd3);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      nxt();
      reset       = ($urandom_range(0, 399) == 0);
      trace_ready = ($urandom_range(0, 99) < 45);
      wb_pc       = ($urandom_range(0, 19) == 0) ? 32'hfffffffc : $urandom;
      wb_res      = $urandom;
      wb_hi       = $urandom;
      wb_lo       = $urandom;
      wb_rdata    = $urandom;
      wb_load     = ($urandom_range(0, 5) == 0);
      wb_al       = ($urandom_range(0, 5) == 0);
      wb_regwen   = ($urandom_range(0, 9) < 7);
      wb_wreg     = 6'($urandom_range(0, 40));
      wb_rhilo    = 2'($urandom);
      wb_whilo    = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
    end
    nxt(); reset = 1'b0; bubble();
    smp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
